// File: rtl/neuron_mac_sequencer_if.sv
// Handshake and data bundle between neuron_mac_sequencer and its coefficient/sample muxes.
// The master modport is the sequencer itself; the slave modport is the surrounding datapath.
interface neuron_mac_sequencer_if #(
    parameter int Width    = 3,
    parameter int InWidth  = 8,
    parameter int AccWidth = 16
);
    logic                       start;
    logic signed [Width-1:0]    coeff_in;
    logic signed [InWidth-1:0]  x_in;
    logic [4:0]                 SEL;
    logic                       busy;
    logic                       done;
    logic signed [AccWidth-1:0] acc_out;

    modport master (
        input  start,
        input  coeff_in,
        input  x_in,
        output SEL,
        output busy,
        output done,
        output acc_out
    );

    modport slave (
        output start,
        output coeff_in,
        output x_in,
        input  SEL,
        input  busy,
        input  done,
        input  acc_out
    );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// Neuron dot-product engine: walks SEL over NumTaps taps, accumulates coeff_in*x_in, reports the sum.
// Optional build macro NEURON_RELU_EN clamps negative results to zero at the output register.
module neuron_mac_sequencer #(
    parameter int Width    = 3,
    parameter int InWidth  = 8,
    parameter int AccWidth = 16,
    parameter int NumTaps  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuron_mac_sequencer_if.master bus
);
    localparam int PW = Width + InWidth;

    // State bits double as the busy/done decodes so those outputs come straight off flops.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [4:0] LAST_SEL = 5'(NumTaps - 1);

    logic [1:0]                 state_r;
    logic [1:0]                 state_nxt_s;
    logic [4:0]                 sel_r;
    logic [4:0]                 sel_nxt_s;
    logic signed [AccWidth-1:0] acc_r;
    logic signed [AccWidth-1:0] acc_nxt_s;
    logic signed [AccWidth-1:0] acc_out_r;
    logic signed [AccWidth-1:0] acc_out_nxt_s;

    logic signed [PW-1:0]       coeff_ext_s;
    logic signed [PW-1:0]       x_ext_s;
    logic signed [PW-1:0]       product_s;
    logic signed [AccWidth-1:0] product_ext_s;
    logic signed [AccWidth-1:0] sum_s;
    logic signed [AccWidth-1:0] result_s;

    // Full-precision signed product, sign-extended into the accumulator width.
    assign coeff_ext_s   = {{InWidth{bus.coeff_in[Width-1]}}, bus.coeff_in};
    assign x_ext_s       = {{Width{bus.x_in[InWidth-1]}}, bus.x_in};
    assign product_s     = coeff_ext_s * x_ext_s;
    assign product_ext_s = {{(AccWidth-PW){product_s[PW-1]}}, product_s};
    assign sum_s         = acc_r + product_ext_s;

    // Output activation applied only to the value captured into acc_out.
`ifdef NEURON_RELU_EN
    assign result_s = sum_s[AccWidth-1] ? {AccWidth{1'b0}} : sum_s;
`else
    assign result_s = sum_s;
`endif

    // Next-state, tap index and accumulator update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_nxt_s   = state_r;
        sel_nxt_s     = sel_r;
        acc_nxt_s     = acc_r;
        acc_out_nxt_s = acc_out_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                sel_nxt_s = 5'd0;
                if (bus.start) begin
                    state_nxt_s = ST_RUN;
                    acc_nxt_s   = {AccWidth{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_nxt_s = sum_s;
                if (sel_r == LAST_SEL) begin
                    acc_out_nxt_s = result_s;
                    sel_nxt_s     = 5'd0;
                    state_nxt_s   = ST_DONE;
                end else begin
                    sel_nxt_s     = sel_r + 5'd1;
                    state_nxt_s   = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = 5'd0;
                acc_nxt_s   = {AccWidth{1'b0}};
            end
        endcase
    end

    // Sequencer registers with asynchronous clear; a mid-run reset discards the partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            sel_r     <= 5'd0;
            acc_r     <= {AccWidth{1'b0}};
            acc_out_r <= {AccWidth{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            sel_r     <= sel_nxt_s;
            acc_r     <= acc_nxt_s;
            acc_out_r <= acc_out_nxt_s;
        end
    end

    assign bus.SEL     = sel_r;
    assign bus.busy    = state_r[0];
    assign bus.done    = state_r[1];
    assign bus.acc_out = acc_out_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed self-checking bench for neuron_mac_sequencer (default 32-tap instance plus a 5-tap instance).
module tb_neuron_mac_sequencer;
    localparam int NT = 32;

    logic clk;
    logic rst_n;
    int   mode;
    int   n_pass;
    int   n_checks;

    neuron_mac_sequencer_if #(.Width(3), .InWidth(8), .AccWidth(16)) bus ();
    neuron_mac_sequencer_if #(.Width(3), .InWidth(8), .AccWidth(16)) bus5 ();

    neuron_mac_sequencer #(.Width(3), .InWidth(8), .AccWidth(16), .NumTaps(NT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    neuron_mac_sequencer #(.Width(3), .InWidth(8), .AccWidth(16), .NumTaps(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux models: coefficient and sample are combinational functions of SEL.
    always_comb begin
        bus.coeff_in = 3'sd1;
        bus.x_in     = 8'sd1;
        case (mode)
            1: begin bus.coeff_in = 3'sb100; bus.x_in = 8'sh80;               end
            2: begin bus.coeff_in = 3'sb100; bus.x_in = 8'sd127;              end
            3: begin bus.coeff_in = 3'sd1;   bus.x_in = {3'b000, bus.SEL};    end
            default: begin bus.coeff_in = 3'sd1; bus.x_in = 8'sd1;            end
        endcase
        bus5.coeff_in = 3'sd2;
        bus5.x_in     = 8'sd3;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One full operation from IDLE; optionally toggles start while busy.
    task automatic run_op(input int m, input int exp, input string tag, input bit toggle);
        @(negedge clk);
        mode      = m;
        bus.start = 1'b1;
        for (int k = 0; k < NT; k++) begin
            @(negedge clk);
            bus.start = toggle ? ((k % 3) == 0) : 1'b0;
            chk({tag, "_sel"}, {27'd0, bus.SEL}, k);
            if (k == 0 || k == NT-1) chk({tag, "_busy"}, {31'd0, bus.busy}, 1);
            if (k == 0) chk({tag, "_nodone"}, {31'd0, bus.done}, 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_done"}, {31'd0, bus.done}, 1);
        chk({tag, "_busy_lo"}, {31'd0, bus.busy}, 0);
        chk({tag, "_acc"}, bus.acc_out, exp);
        @(negedge clk);
        chk({tag, "_done_lo"}, {31'd0, bus.done}, 0);
        chk({tag, "_acc_hold"}, bus.acc_out, exp);
    endtask

    initial begin
        int saw_done;
        int exp_neg;
        n_pass     = 0;
        n_checks   = 0;
        mode       = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus5.start = 1'b0;
`ifdef NEURON_RELU_EN
        exp_neg = 0;
`else
        exp_neg = -16256;
`endif

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_sel",  {27'd0, bus.SEL},  0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_acc",  bus.acc_out,       0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 0);

        run_op(0, 32,      "ones",    1'b0);
        run_op(1, 16384,   "neg_neg", 1'b0);
        run_op(2, exp_neg, "neg_pos", 1'b0);
        run_op(3, 496,     "ramp",    1'b1);

        // start held high: back-to-back results every NT+1 cycles
        @(negedge clk);
        mode      = 0;
        bus.start = 1'b1;
        for (int op = 0; op < 2; op++) begin
            for (int k = 0; k < NT; k++) begin
                @(negedge clk);
                chk("held_sel", {27'd0, bus.SEL}, k);
                if (k == 0) chk("held_busy", {31'd0, bus.busy}, 1);
            end
            @(negedge clk);
            chk("held_done", {31'd0, bus.done}, 1);
            chk("held_acc",  bus.acc_out,       32);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("held_idle_busy", {31'd0, bus.busy}, 0);
        chk("held_idle_done", {31'd0, bus.done}, 0);

        // Reset in the middle of a run
        @(negedge clk);
        mode      = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_sel10", {27'd0, bus.SEL}, 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel",  {27'd0, bus.SEL},  0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 0);
        chk("mid_rst_done", {31'd0, bus.done}, 0);
        chk("mid_rst_acc",  bus.acc_out,       0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 0;
        for (int k = 0; k < NT + 4; k++) begin
            @(negedge clk);
            if (bus.done) saw_done++;
        end
        chk("mid_rst_no_done", saw_done, 0);
        run_op(3, 496, "post_rst", 1'b0);

        // 5-tap instance
        @(negedge clk);
        bus5.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus5.start = 1'b0;
            chk("t5_sel", {27'd0, bus5.SEL}, k);
        end
        @(negedge clk);
        chk("t5_done", {31'd0, bus5.done}, 1);
        chk("t5_acc",  bus5.acc_out,       30);
        chk("t5_sel0", {27'd0, bus5.SEL},  0);
        @(negedge clk);
        chk("t5_done_lo", {31'd0, bus5.done}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
